// File: rtl/pi_pkg.sv
// Shared definitions for the pi switch datapath: direction codes, arbiter latency,
// port indices and packet field position helpers.
package pi_pkg;

    typedef enum logic [1:0] {
        VOID  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        UP    = 2'b11
    } dir_t;

    // Select codes share the 2-bit space; the two up links are distinguished by
    // code, so UPL/UPR alias UP/VOID rather than being separate enum members.
    localparam dir_t UPL = UP;
    localparam dir_t UPR = VOID;

    localparam int ARB_LAT   = 5;
    localparam int NUM_PORTS = 4;

    typedef enum logic [1:0] {
        PORT_L  = 2'd0,
        PORT_R  = 2'd1,
        PORT_UL = 2'd2,
        PORT_UR = 2'd3
    } port_t;

    function automatic int valid_bit(input int p_w);
        return p_w - 1;
    endfunction

    function automatic int addr_msb(input int p_w);
        return p_w - 2;
    endfunction

    function automatic int addr_lsb(input int p_w, input int a_w);
        return p_w - 1 - a_w;
    endfunction

    function automatic port_t sel_source(input dir_t sel);
        case (sel)
            LEFT:    return PORT_L;
            RIGHT:   return PORT_R;
            UPL:     return PORT_UL;
            UPR:     return PORT_UR;
            default: return PORT_UR;
        endcase
    endfunction

    function automatic logic port_wants(input port_t port, input dir_t want);
        case (port)
            PORT_L:  return want == LEFT;
            PORT_R:  return want == RIGHT;
            default: return want == UP;
        endcase
    endfunction

endpackage

// File: rtl/pi_delay_line.sv
// Fixed-depth register chain that holds packets while the arbiter decides;
// every stage clears on the asynchronous reset.
module pi_delay_line
    import pi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset; a stale valid bit left in this chain would
    // surface later as a phantom packet, so it is not treated like a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pi_route_dp.sv
// Pi switch datapath: captures four links, decodes desired directions for the
// arbiter, delays packets ARB_LAT cycles and switches them by the returned selects.
// Optional PI_ROUTE_STATS_EN adds forwarded/deflected packet counters.
module pi_route_dp
    import pi_pkg::*;
#(
    parameter int P_W   = 49,
    parameter int A_W   = 8,
    parameter int LEVEL = 1,
    parameter logic [A_W-LEVEL-2:0] SUBTREE = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [P_W-1:0] l_bus_i,
    input  logic [P_W-1:0] r_bus_i,
    input  logic [P_W-1:0] ul_bus_i,
    input  logic [P_W-1:0] ur_bus_i,
    output logic [1:0]     d_l,
    output logic [1:0]     d_r,
    output logic [1:0]     d_ul,
    output logic [1:0]     d_ur,
    input  logic [1:0]     sel_l,
    input  logic [1:0]     sel_r,
    input  logic [1:0]     sel_ul,
    input  logic [1:0]     sel_ur,
    output logic [P_W-1:0] l_bus_o,
    output logic [P_W-1:0] r_bus_o,
    output logic [P_W-1:0] ul_bus_o,
    output logic [P_W-1:0] ur_bus_o
`ifdef PI_ROUTE_STATS_EN
    ,
    output logic [31:0]    fwd_cnt,
    output logic [31:0]    defl_cnt
`endif
);

    localparam int VB = valid_bit(P_W);
    localparam int AL = addr_lsb(P_W, A_W);

    logic [P_W-1:0] in_bus  [NUM_PORTS];
    logic [P_W-1:0] stg0    [NUM_PORTS];
    dir_t           dir0    [NUM_PORTS];
    dir_t           d_q     [NUM_PORTS];
    dir_t           sel     [NUM_PORTS];
    logic [P_W-1:0] dly_pkt [NUM_PORTS];
    logic [P_W-1:0] mux_pkt [NUM_PORTS];
    logic [P_W-1:0] out_q   [NUM_PORTS];
`ifdef PI_ROUTE_STATS_EN
    dir_t           dly_dir [NUM_PORTS];
`endif

    assign in_bus[PORT_L]  = l_bus_i;
    assign in_bus[PORT_R]  = r_bus_i;
    assign in_bus[PORT_UL] = ul_bus_i;
    assign in_bus[PORT_UR] = ur_bus_i;

    assign sel[PORT_L]  = dir_t'(sel_l);
    assign sel[PORT_R]  = dir_t'(sel_r);
    assign sel[PORT_UL] = dir_t'(sel_ul);
    assign sel[PORT_UR] = dir_t'(sel_ur);

    // Down-routing only when the packet's upper address bits name this subtree.
    function automatic dir_t decode(input logic [P_W-1:0] pkt);
        logic [A_W-1:0] addr;
        addr = pkt[AL +: A_W];
        if (!pkt[VB]) begin
            return VOID;
        end
        if (addr[A_W-1:LEVEL+1] == SUBTREE) begin
            return addr[LEVEL] ? RIGHT : LEFT;
        end
        return UP;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            dir0[p] = decode(stg0[p]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                stg0[p] <= '0;
                d_q[p]  <= VOID;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                stg0[p] <= in_bus[p];
                d_q[p]  <= dir0[p];
            end
        end
    end

    assign d_l  = d_q[PORT_L];
    assign d_r  = d_q[PORT_R];
    assign d_ul = d_q[PORT_UL];
    assign d_ur = d_q[PORT_UR];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
`ifdef PI_ROUTE_STATS_EN
        logic [P_W+1:0] dly_out;

        pi_delay_line #(
            .WIDTH(P_W + 2),
            .DEPTH(ARB_LAT)
        ) u_dly (
            .clk  (clk),
            .reset(reset),
            .din  ({dir0[p], stg0[p]}),
            .dout (dly_out)
        );

        assign dly_pkt[p] = dly_out[P_W-1:0];
        assign dly_dir[p] = dir_t'(dly_out[P_W+1:P_W]);
`else
        pi_delay_line #(
            .WIDTH(P_W),
            .DEPTH(ARB_LAT)
        ) u_dly (
            .clk  (clk),
            .reset(reset),
            .din  (stg0[p]),
            .dout (dly_pkt[p])
        );
`endif
    end

    // Duplicate selects of one source are legal (void steering) and not gated.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            mux_pkt[p] = dly_pkt[sel_source(sel[p])];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= mux_pkt[p];
            end
        end
    end

    assign l_bus_o  = out_q[PORT_L];
    assign r_bus_o  = out_q[PORT_R];
    assign ul_bus_o = out_q[PORT_UL];
    assign ur_bus_o = out_q[PORT_UR];

`ifdef PI_ROUTE_STATS_EN
    logic [2:0] fwd_inc;
    logic [2:0] defl_inc;

    // NOTE: both increments get a default first so this block cannot infer latches.
    always_comb begin
        fwd_inc  = '0;
        defl_inc = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (mux_pkt[p][VB]) begin
                if (port_wants(port_t'(p[1:0]), dly_dir[sel_source(sel[p])])) begin
                    fwd_inc = fwd_inc + 3'd1;
                end else begin
                    defl_inc = defl_inc + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt  <= '0;
            defl_cnt <= '0;
        end else begin
            fwd_cnt  <= fwd_cnt + 32'(fwd_inc);
            defl_cnt <= defl_cnt + 32'(defl_inc);
        end
    end
`endif

endmodule

// File: tb/tb_pi_route_dp.sv
// Scoreboard bench for pi_route_dp: a driver feeds random and directed traffic and
// queues the expected outputs from a spec-level model; a monitor pops and compares.
module tb_pi_route_dp;

    localparam int P_W = 49;
    localparam int A_W = 8;
    localparam int LEVEL = 1;
    localparam int SUBTREE = 0;

    typedef logic [P_W-1:0] pkt_t;

    typedef struct packed {
        logic [3:0][P_W-1:0] out;
        logic [3:0][1:0]     d;
        logic [31:0]         fwd;
        logic [31:0]         defl;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    pkt_t l_bus_i, r_bus_i, ul_bus_i, ur_bus_i;
    pkt_t l_bus_o, r_bus_o, ul_bus_o, ur_bus_o;
    logic [1:0] d_l, d_r, d_ul, d_ur;
    logic [1:0] sel_l, sel_r, sel_ul, sel_ur;
`ifdef PI_ROUTE_STATS_EN
    logic [31:0] fwd_cnt, defl_cnt;
`endif

    pi_route_dp dut (
        .clk     (clk),
        .reset   (reset),
        .l_bus_i (l_bus_i),
        .r_bus_i (r_bus_i),
        .ul_bus_i(ul_bus_i),
        .ur_bus_i(ur_bus_i),
        .d_l     (d_l),
        .d_r     (d_r),
        .d_ul    (d_ul),
        .d_ur    (d_ur),
        .sel_l   (sel_l),
        .sel_r   (sel_r),
        .sel_ul  (sel_ul),
        .sel_ur  (sel_ur),
        .l_bus_o (l_bus_o),
        .r_bus_o (r_bus_o),
        .ul_bus_o(ul_bus_o),
        .ur_bus_o(ur_bus_o)
`ifdef PI_ROUTE_STATS_EN
        ,
        .fwd_cnt (fwd_cnt),
        .defl_cnt(defl_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;
    int cyc = 0;

    pkt_t       drv_in  [4];
    logic [1:0] drv_sel [4];
    logic       drv_rst;

    // hist[k][p]: packet captured on input p, k+1 cycles before the edge being predicted
    logic [3:0][P_W-1:0] hist [6];
    logic [31:0] m_fwd = '0;
    logic [31:0] m_defl = '0;
    exp_t exp_q [$];

    logic [3:0][P_W-1:0] act_out;
    logic [3:0][1:0]     act_d;
    assign act_out = {ur_bus_o, ul_bus_o, r_bus_o, l_bus_o};
    assign act_d   = {d_ur, d_ul, d_r, d_l};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Desired direction straight from the addressing rules.
    function automatic logic [1:0] want_dir(input pkt_t pk);
        int addr;
        addr = int'(pk[P_W-2 -: A_W]);
        if (!pk[P_W-1]) return 2'b00;
        if ((addr >> (LEVEL + 1)) == SUBTREE) return (((addr >> LEVEL) % 2) == 1) ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    function automatic int src_of(input logic [1:0] s);
        case (s)
            2'b01:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit forwarded(input int port, input logic [1:0] want);
        if (port == 0) return want == 2'b01;
        if (port == 1) return want == 2'b10;
        return want == 2'b11;
    endfunction

    function automatic pkt_t mk_pkt(input logic [7:0] addr, input int port);
        return {1'b1, addr, 2'(port), 14'(cyc), 24'($urandom)};
    endfunction

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    task automatic set_idle();
        for (int p = 0; p < 4; p++) begin
            drv_in[p]  = '0;
            drv_sel[p] = 2'b10;
        end
    endtask

    task automatic perm_sel();
        logic [1:0] codes [4];
        logic [1:0] t;
        int j;
        codes[0] = 2'b01; codes[1] = 2'b10; codes[2] = 2'b11; codes[3] = 2'b00;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = codes[i]; codes[i] = codes[j]; codes[j] = t;
        end
        for (int p = 0; p < 4; p++) drv_sel[p] = codes[p];
    endtask

    // Drive one cycle's inputs, queue the prediction for the coming edge, then
    // return just after that edge.
    task automatic step();
        exp_t e;
        reset    = drv_rst;
        l_bus_i  = drv_in[0];
        r_bus_i  = drv_in[1];
        ul_bus_i = drv_in[2];
        ur_bus_i = drv_in[3];
        sel_l    = drv_sel[0];
        sel_r    = drv_sel[1];
        sel_ul   = drv_sel[2];
        sel_ur   = drv_sel[3];
        e = '0;
        if (drv_rst) begin
            foreach (hist[i]) hist[i] = '0;
            m_fwd  = '0;
            m_defl = '0;
            foreach (exp_q[i]) exp_q[i] = '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                e.out[p] = hist[5][src_of(drv_sel[p])];
                e.d[p]   = want_dir(hist[0][p]);
                if (e.out[p][P_W-1]) begin
                    if (forwarded(p, want_dir(e.out[p]))) m_fwd++;
                    else m_defl++;
                end
            end
            e.fwd  = m_fwd;
            e.defl = m_defl;
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            for (int p = 0; p < 4; p++) hist[0][p] = drv_in[p];
        end
        exp_q.push_back(e);
        started = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: after every edge, compare what the DUT shows with the oldest prediction.
    initial begin : monitor
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: no prediction queued at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                for (int p = 0; p < 4; p++) begin
                    check($sformatf("sb_out%0d", p), 64'(act_out[p]), 64'(e.out[p]));
                    check($sformatf("sb_d%0d", p), 64'(act_d[p]), 64'(e.d[p]));
                end
`ifdef PI_ROUTE_STATS_EN
                check("sb_fwd_cnt", 64'(fwd_cnt), 64'(e.fwd));
                check("sb_defl_cnt", 64'(defl_cnt), 64'(e.defl));
`endif
            end
        end
    end

    initial begin : driver
        pkt_t a;
        reset = 1'b1;
        {l_bus_i, r_bus_i, ul_bus_i, ur_bus_i} = '0;
        {sel_l, sel_r, sel_ul, sel_ur} = '0;
        foreach (hist[i]) hist[i] = '0;
        set_idle();
        drv_rst = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) step();
        check("rst_l_bus", 64'(l_bus_o), 64'd0);
        check("rst_d_ur", 64'(d_ur), 64'd0);
        drv_rst = 1'b0;

        // Decode: in-subtree, out-of-subtree, invalid on the ul link
        set_idle();
        drv_in[2] = mk_pkt(8'h02, 2);
        step();
        drv_in[2] = mk_pkt(8'h04, 2);
        step();
        check("dec_in_subtree", 64'(d_ul), 64'(2'b10));
        a = mk_pkt(8'h02, 2);
        a[P_W-1] = 1'b0;
        drv_in[2] = a;
        step();
        check("dec_out_subtree", 64'(d_ul), 64'(2'b11));
        drv_in[2] = '0;
        step();
        check("dec_invalid", 64'(d_ul), 64'(2'b00));

        // Alignment: one l packet, picked up by r exactly six edges later
        set_idle();
        repeat (6) step();
        a = mk_pkt(8'h01, 0);
        drv_in[0] = a;
        step();
        drv_in[0] = '0;
        repeat (5) step();
        check("align_early", 64'(r_bus_o), 64'd0);
        drv_sel[1] = 2'b01;
        step();
        check("align_hit", 64'(r_bus_o), 64'(a));
        drv_sel[1] = 2'b10;
        step();
        check("align_late", 64'(r_bus_o), 64'd0);

        // Full load with permuted selects, then flush
        for (int c = 0; c < 100; c++) begin
            for (int p = 0; p < 4; p++) drv_in[p] = mk_pkt(rand_addr(), p);
            perm_sel();
            step();
        end
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 4; p++) drv_in[p] = '0;
            perm_sel();
            step();
        end

        // Mixed traffic with arbitrary (possibly duplicate) selects
        for (int c = 0; c < 150; c++) begin
            for (int p = 0; p < 4; p++) begin
                drv_in[p]  = ($urandom_range(0, 3) != 0) ? mk_pkt(rand_addr(), p) : '0;
                drv_sel[p] = 2'($urandom);
            end
            step();
        end

        // Reset mid-flight: four injected cycles must never emerge
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) drv_in[p] = mk_pkt(rand_addr(), p);
            perm_sel();
            step();
        end
        for (int p = 0; p < 4; p++) drv_in[p] = '0;
        repeat (2) step();
        drv_rst = 1'b1;
        step();
        check("midrst_l", 64'(l_bus_o), 64'd0);
        check("midrst_r", 64'(r_bus_o), 64'd0);
        check("midrst_ul", 64'(ul_bus_o), 64'd0);
        check("midrst_ur", 64'(ur_bus_o), 64'd0);
        check("midrst_d_l", 64'(d_l), 64'd0);
        step();
        drv_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            perm_sel();
            step();
        end

`ifdef PI_ROUTE_STATS_EN
        // Counters: 10 LEFT-wanting packets, 4 to l and 6 deflected to r
        set_idle();
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        for (int s = 0; s < 16; s++) begin
            set_idle();
            if (s < 10) drv_in[0] = mk_pkt(8'h00, 0);
            if (s >= 6) begin
                if (s - 6 < 4) drv_sel[0] = 2'b01;
                else drv_sel[1] = 2'b01;
            end
            step();
        end
        set_idle();
        repeat (2) step();
        check("stats_fwd", 64'(fwd_cnt), 64'd4);
        check("stats_defl", 64'(defl_cnt), 64'd6);

        // Wrap: preload the forward counter at all-ones, then forward one packet
        force dut.fwd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fwd_cnt;
        m_fwd = 32'hFFFF_FFFF;
        foreach (exp_q[i]) exp_q[i].fwd = 32'hFFFF_FFFF;
        drv_in[0] = mk_pkt(8'h00, 0);
        step();
        drv_in[0] = '0;
        repeat (5) step();
        drv_sel[0] = 2'b01;
        step();
        check("stats_wrap", 64'(fwd_cnt), 64'd0);
        set_idle();
        step();
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
